rs232_cmd_responder: RTL and testbench



---
 rtl/rs232_cmd_responder_if.sv | 42 ++++
 rtl/rs232_cmd_responder.sv | 171 +++++++++++++++++
 tb/tb_rs232_cmd_responder.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_cmd_responder_if.sv
// ---------------------------------------------------------------------------
// rs232_cmd_responder_if
// Groups the UART byte handshake, the generic memory port and the status
// outputs of rs232_cmd_responder.
//   master : the responder (consumes rx bytes, drives tx and memory strobes)
//   slave  : the environment (UART + memory)
// Signals:
//   rx_rdy/rx_data          received byte pulse and value
//   tx_busy/ena_tx/tx_data  transmit handshake
//   mem_addr/mem_wr_ena/mem_wr_data/mem_rd_req/mem_rd_rdy/mem_rd_data
//                           single-byte write / read memory port
//   busy/err                responder status (not idle / timeout abort pulse)
// ---------------------------------------------------------------------------
interface rs232_cmd_responder_if #(
    parameter int ADDR_W = 20
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              tx_busy;
    logic              ena_tx;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_ena;
    logic [7:0]        mem_wr_data;
    logic              mem_rd_req;
    logic              mem_rd_rdy;
    logic [7:0]        mem_rd_data;
    logic              busy;
    logic              err;

    modport master (
        input  rx_rdy, rx_data, tx_busy, mem_rd_rdy, mem_rd_data,
        output ena_tx, tx_data, mem_addr, mem_wr_ena, mem_wr_data,
               mem_rd_req, busy, err
    );

    modport slave (
        output rx_rdy, rx_data, tx_busy, mem_rd_rdy, mem_rd_data,
        input  ena_tx, tx_data, mem_addr, mem_wr_ena, mem_wr_data,
               mem_rd_req, busy, err
    );
endinterface

// File: rtl/rs232_cmd_responder.sv
// ---------------------------------------------------------------------------
// rs232_cmd_responder
// Host-link responder behind a byte UART. Parses 5-byte packets
// (CMD, A2, A1, A0, ARG, MSB first) and performs either a single-byte memory
// write (CMD_WR, ARG = data) or a burst read of ARG+1 bytes (CMD_RD) whose
// data is returned one byte at a time through the UART transmit handshake.
// A watchdog aborts stalled packets and unanswered reads with an err pulse.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      rs232_cmd_responder_if.master (UART, memory port, busy/err)
// ---------------------------------------------------------------------------
module rs232_cmd_responder #(
    parameter int         ADDR_W       = 20,
    parameter int         TIMEOUT_CLKS = 500000,
    parameter logic [7:0] CMD_WR       = 8'h57,
    parameter logic [7:0] CMD_RD       = 8'h52
) (
    input logic                   clk,
    input logic                   reset_n,
    rs232_cmd_responder_if.master bus
);

    localparam int               TMR_W      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CLKS);

    typedef enum logic [3:0] {
        IDLE, GET_A2, GET_A1, GET_A0, GET_ARG, DO_WR, RD_REQ, RD_WAIT, TX_SEND
    } state_t;

    state_t            state;
    logic              is_rd;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        count;
    logic [TMR_W-1:0]  timer;
    logic              ena_tx;
    logic [7:0]        tx_data;
    logic              wr_ena;
    logic [7:0]        wr_data;
    logic              rd_req;
    logic              err;

    // The timer is reloaded on every accepted event, so it reaching 1 while
    // still waiting means this clk is the last one allowed: abort now.
    logic              tmr_exp;
    assign tmr_exp = (timer <= TMR_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            is_rd   <= 1'b0;
            addr    <= '0;
            count   <= '0;
            timer   <= '0;
            ena_tx  <= 1'b0;
            tx_data <= '0;
            wr_ena  <= 1'b0;
            wr_data <= '0;
            rd_req  <= 1'b0;
            err     <= 1'b0;
        end else begin
            ena_tx <= 1'b0;
            wr_ena <= 1'b0;
            rd_req <= 1'b0;
            err    <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.rx_rdy && (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD)) begin
                        is_rd <= (bus.rx_data == CMD_RD);
                        timer <= TMR_RELOAD;
                        state <= GET_A2;
                    end
                end

                // Address bytes shift in MSB first; truncating to ADDR_W
                // after each shift leaves exactly A[ADDR_W-1:0] after A0.
                GET_A2, GET_A1, GET_A0: begin
                    if (bus.rx_rdy) begin
                        addr  <= ADDR_W'({addr, bus.rx_data});
                        timer <= TMR_RELOAD;
                        case (state)
                            GET_A2:  state <= GET_A1;
                            GET_A1:  state <= GET_A0;
                            default: state <= GET_ARG;
                        endcase
                    end else if (tmr_exp) begin
                        err   <= 1'b1;
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                // Strobes are raised together with the state change so they
                // appear on the clk right after the ARG byte.
                GET_ARG: begin
                    if (bus.rx_rdy) begin
                        timer <= TMR_RELOAD;
                        if (is_rd) begin
                            count  <= bus.rx_data;
                            rd_req <= 1'b1;
                            state  <= RD_REQ;
                        end else begin
                            wr_data <= bus.rx_data;
                            wr_ena  <= 1'b1;
                            state   <= DO_WR;
                        end
                    end else if (tmr_exp) begin
                        err   <= 1'b1;
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                DO_WR: begin
                    state <= IDLE;
                end

                RD_REQ: begin
                    timer <= TMR_RELOAD;
                    state <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (bus.mem_rd_rdy) begin
                        tx_data <= bus.mem_rd_data;
                        state   <= TX_SEND;
                    end else if (tmr_exp) begin
                        err   <= 1'b1;
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                // tx_busy only rises the clk after ena_tx, so the ena_tx
                // term keeps two loads from landing on back-to-back clks.
                TX_SEND: begin
                    if (!bus.tx_busy && !ena_tx) begin
                        ena_tx <= 1'b1;
                        if (count == 8'd0) begin
                            state <= IDLE;
                        end else begin
                            count  <= count - 8'd1;
                            addr   <= addr + 1'b1;
                            rd_req <= 1'b1;
                            state  <= RD_REQ;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ena_tx      = ena_tx;
    assign bus.tx_data     = tx_data;
    assign bus.mem_addr    = addr;
    assign bus.mem_wr_ena  = wr_ena;
    assign bus.mem_wr_data = wr_data;
    assign bus.mem_rd_req  = rd_req;
    assign bus.busy        = (state != IDLE);
    assign bus.err         = err;

endmodule

// File: tb/tb_rs232_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_rs232_cmd_responder
// Drives packets into rs232_cmd_responder (ADDR_W=20, short timeout) with a
// UART model (tx_busy held 20 clks per byte) and a memory model returning
// addr[7:0]^0x3C after 3 clks, then checks strobes, tx bytes and err.
// ---------------------------------------------------------------------------
module tb_rs232_cmd_responder;

    localparam int TMO = 40;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    rs232_cmd_responder_if #(.ADDR_W(20)) bus ();

    rs232_cmd_responder #(
        .ADDR_W       (20),
        .TIMEOUT_CLKS (TMO),
        .CMD_WR       (8'h57),
        .CMD_RD       (8'h52)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // UART model
    logic hold_busy = 1'b0;
    int   ubusy     = 0;
    always @(posedge clk) begin
        if (bus.ena_tx)     ubusy <= 20;
        else if (ubusy > 0) ubusy <= ubusy - 1;
    end
    assign bus.tx_busy = hold_busy || (ubusy != 0);

    // Memory model
    logic        mem_mute  = 1'b0;
    logic        mem_rdy_r = 1'b0;
    logic [7:0]  mem_dat_r = 8'h00;
    logic [19:0] pend_addr = 20'h0;
    int          pend      = 0;
    logic [19:0] rd_q[$];
    always @(posedge clk) begin
        mem_rdy_r <= 1'b0;
        if (bus.mem_rd_req) begin
            rd_q.push_back(bus.mem_addr);
            pend      <= 3;
            pend_addr <= bus.mem_addr;
        end else if (pend > 1) begin
            pend <= pend - 1;
        end else if (pend == 1) begin
            pend <= 0;
            if (!mem_mute) begin
                mem_rdy_r <= 1'b1;
                mem_dat_r <= pend_addr[7:0] ^ 8'h3C;
            end
        end
    end
    assign bus.mem_rd_rdy  = mem_rdy_r;
    assign bus.mem_rd_data = mem_dat_r;

    // Monitors
    logic [7:0]  tx_q[$];
    logic [19:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int   err_cnt  = 0;
    int   dbl_cnt  = 0;
    logic ena_prev = 1'b0;
    always @(posedge clk) begin
        if (bus.ena_tx) tx_q.push_back(bus.tx_data);
        if (bus.ena_tx && ena_prev) dbl_cnt <= dbl_cnt + 1;
        ena_prev <= bus.ena_tx;
        if (bus.err) err_cnt <= err_cnt + 1;
        if (bus.mem_wr_ena) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wr_data);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Starts #1 after an edge; the byte is sampled gap+1 edges later.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (bus.busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_idle_reached"}, (n < 2000), 1);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_ena_tx"},      bus.ena_tx,      0);
        chk({nm, "_tx_data"},     bus.tx_data,     0);
        chk({nm, "_mem_addr"},    bus.mem_addr,    0);
        chk({nm, "_mem_wr_ena"},  bus.mem_wr_ena,  0);
        chk({nm, "_mem_wr_data"}, bus.mem_wr_data, 0);
        chk({nm, "_mem_rd_req"},  bus.mem_rd_req,  0);
        chk({nm, "_busy"},        bus.busy,        0);
        chk({nm, "_err"},         bus.err,         0);
    endtask

    typedef struct {
        logic [47:0] pkt;        // bytes MSB first, right-aligned
        int          nb;
        int          exp_wr;
        logic [19:0] exp_waddr;
        logic [7:0]  exp_wdata;
        int          exp_ntx;
        logic [19:0] exp_raddr;  // first read address
        logic [23:0] exp_tx;     // tx byte j at [8*j +: 8]
        int          exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int b_tx, b_rd, b_wr, b_err, n;
        vec_t v;

        vecs[0] = '{48'h57_01_23_45_A5, 5, 1, 20'h12345, 8'hA5, 0, 20'h00000, 24'h000000, 0};
        vecs[1] = '{48'h52_00_00_FE_02, 5, 0, 20'h00000, 8'h00, 3, 20'h000FE, 24'h3CC3C2, 0};
        vecs[2] = '{48'h52_FF_FF_FF_01, 5, 0, 20'h00000, 8'h00, 2, 20'hFFFFF, 24'h003CC3, 0};
        vecs[3] = '{48'h57_AB_CD_EF_11, 5, 1, 20'hBCDEF, 8'h11, 0, 20'h00000, 24'h000000, 0};
        vecs[4] = '{48'h33_57_00_00_10_5A, 6, 1, 20'h00010, 8'h5A, 0, 20'h00000, 24'h000000, 0};
        vecs[5] = '{48'h52_00_12_34_00, 5, 0, 20'h00000, 8'h00, 1, 20'h01234, 24'h000008, 0};
        vecs[6] = '{48'h57_00, 2, 0, 20'h00000, 8'h00, 0, 20'h00000, 24'h000000, 1};
        vecs[7] = '{48'h52_00_00_01, 4, 0, 20'h00000, 8'h00, 0, 20'h00000, 24'h000000, 1};

        reset_n     = 1'b0;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven packets
        for (int i = 0; i < 8; i++) begin
            v     = vecs[i];
            b_tx  = tx_q.size();
            b_rd  = rd_q.size();
            b_wr  = wa_q.size();
            b_err = err_cnt;
            for (int k = 0; k < v.nb; k++)
                send_byte(v.pkt[(v.nb-1-k)*8 +: 8], 2);
            wait_idle($sformatf("v%0d", i));
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr_count", i), wa_q.size() - b_wr, v.exp_wr);
            if (v.exp_wr == 1 && wa_q.size() > b_wr) begin
                chk($sformatf("v%0d_wr_addr", i), wa_q[b_wr], v.exp_waddr);
                chk($sformatf("v%0d_wr_data", i), wd_q[b_wr], v.exp_wdata);
            end
            chk($sformatf("v%0d_tx_count", i), tx_q.size() - b_tx, v.exp_ntx);
            chk($sformatf("v%0d_rd_count", i), rd_q.size() - b_rd, v.exp_ntx);
            for (int j = 0; j < v.exp_ntx; j++) begin
                if (b_tx + j < tx_q.size())
                    chk($sformatf("v%0d_tx_byte%0d", i, j), tx_q[b_tx+j], v.exp_tx[8*j +: 8]);
                if (b_rd + j < rd_q.size())
                    chk($sformatf("v%0d_rd_addr%0d", i, j), rd_q[b_rd+j], 20'(v.exp_raddr + 20'(j)));
            end
            chk($sformatf("v%0d_err_count", i), err_cnt - b_err, v.exp_err);
            chk($sformatf("v%0d_busy", i), bus.busy, 0);
        end

        // Byte arriving on the last allowed clk is accepted
        b_wr = wa_q.size(); b_err = err_cnt;
        send_byte(8'h57, 2);
        send_byte(8'h00, TMO - 1);
        send_byte(8'h00, 2);
        send_byte(8'h10, 2);
        send_byte(8'h5A, 2);
        wait_idle("tmo_edge");
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_edge_wr_count", wa_q.size() - b_wr, 1);
        if (wa_q.size() > b_wr) chk("tmo_edge_wr_addr", wa_q[b_wr], 20'h00010);
        chk("tmo_edge_err_count", err_cnt - b_err, 0);

        // One clk later the packet is aborted; the rest is ignored in IDLE
        b_wr = wa_q.size(); b_err = err_cnt;
        send_byte(8'h57, 2);
        send_byte(8'h00, TMO);
        send_byte(8'h00, 2);
        send_byte(8'h10, 2);
        send_byte(8'h5A, 2);
        wait_idle("tmo_late");
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_late_wr_count", wa_q.size() - b_wr, 0);
        chk("tmo_late_err_count", err_cnt - b_err, 1);

        // Read never answered
        mem_mute = 1'b1;
        b_tx = tx_q.size(); b_rd = rd_q.size(); b_err = err_cnt;
        send_byte(8'h52, 2);
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        send_byte(8'h05, 2);
        send_byte(8'h00, 2);
        chk("rdto_req_latency", bus.mem_rd_req, 1);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.err) break;
        end
        chk("rdto_err_delay", n, TMO + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rdto_err_count", err_cnt - b_err, 1);
        chk("rdto_tx_count", tx_q.size() - b_tx, 0);
        chk("rdto_rd_count", rd_q.size() - b_rd, 1);
        chk("rdto_busy", bus.busy, 0);
        mem_mute = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Reset while stalled in TX_SEND with count=5
        hold_busy = 1'b1;
        b_tx = tx_q.size(); b_rd = rd_q.size(); b_wr = wa_q.size(); b_err = err_cnt;
        send_byte(8'h52, 2);
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        send_byte(8'h40, 2);
        send_byte(8'h05, 2);
        repeat (12) @(posedge clk);
        #1;
        chk("rst_pre_busy", bus.busy, 1);
        chk("rst_pre_tx_data", bus.tx_data, 8'h7C);
        chk("rst_pre_mem_addr", bus.mem_addr, 20'h00040);
        chk("rst_pre_tx_count", tx_q.size() - b_tx, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("rst_async");
        repeat (2) @(posedge clk);
        hold_busy = 1'b0;
        #3;
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("rst_post_tx_count", tx_q.size() - b_tx, 0);
        chk("rst_post_rd_count", rd_q.size() - b_rd, 1);
        chk("rst_post_wr_count", wa_q.size() - b_wr, 0);
        chk("rst_post_err_count", err_cnt - b_err, 0);
        chk("rst_post_busy", bus.busy, 0);

        chk("ena_tx_back_to_back", dbl_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
